// File: rtl/snoop_pkg.sv
// snoop_pkg: shared encodings for the snoop bus controller.
//   line_state_e  - per-line coherence state (invalid / exclusive / shared)
//   bus_op_e      - snooped bus operation
//   fsm_state_e   - controller FSM state
//   to_line_state - maps a raw 2-bit CPU state to a legal line state
package snoop_pkg;

  typedef enum logic [1:0] {
    LsInvalid   = 2'b00,
    LsExclusive = 2'b01,
    LsShared    = 2'b10
  } line_state_e;

  typedef enum logic [1:0] {
    OpReadMiss   = 2'b00,
    OpWriteMiss  = 2'b01,
    OpInvalidate = 2'b10,
    OpReserved   = 2'b11
  } bus_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StLookup = 2'b01,
    StFlush  = 2'b10,
    StDone   = 2'b11
  } fsm_state_e;

  // The unused encoding 11 is stored as invalid.
  function automatic line_state_e to_line_state(logic [1:0] raw);
    case (raw)
      2'b01:   return LsExclusive;
      2'b10:   return LsShared;
      default: return LsInvalid;
    endcase
  endfunction

endpackage

// File: rtl/snoop_line_store.sv
// snoop_line_store: direct-mapped tag/state array.
//   i_clk, i_rst_n                      - clock, async active-low reset
//   i_rd_index -> o_rd_tag, o_rd_state  - combinational read port (snoop side)
//   i_snp_we/index/state                - snoop write port (state only, has priority)
//   i_cpu_we/index/tag/state            - CPU write port (tag and state)
module snoop_line_store
  import snoop_pkg::*;
#(
  parameter int unsigned LINES = 4,
  parameter int unsigned TAG_W = 6,
  localparam int unsigned IDX_W = $clog2(LINES)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [IDX_W-1:0]  i_rd_index,
  output logic [TAG_W-1:0]  o_rd_tag,
  output line_state_e       o_rd_state,
  input  logic              i_snp_we,
  input  logic [IDX_W-1:0]  i_snp_index,
  input  line_state_e       i_snp_state,
  input  logic              i_cpu_we,
  input  logic [IDX_W-1:0]  i_cpu_index,
  input  logic [TAG_W-1:0]  i_cpu_tag,
  input  line_state_e       i_cpu_state
);

  logic [TAG_W-1:0] r_tag   [LINES];
  line_state_e      r_state [LINES];

  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_state = r_state[i_rd_index];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(LINES); i++) begin
        r_tag[i]   <= '0;
        r_state[i] <= LsInvalid;
      end
    end else begin
      for (int i = 0; i < int'(LINES); i++) begin
        if (i_snp_we && (i_snp_index == IDX_W'(i))) begin
          r_state[i] <= i_snp_state;
        end else if (i_cpu_we && (i_cpu_index == IDX_W'(i))) begin
          r_tag[i]   <= i_cpu_tag;
          r_state[i] <= i_cpu_state;
        end
      end
    end
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// snoop_bus_controller: services bus snoops against a direct-mapped line store
// while the local CPU updates lines on a second port.
//   clock, reset_n                      - clock, async active-low reset
//   snoop_valid/op/index/tag, snoop_ready - snoop request handshake
//   cpu_upd_valid/index/tag/state, cpu_upd_stall - CPU line update, stalled on index clash
//   snoop_done, snoop_hit               - one-cycle completion pulse and hit result
//   write_back, abort_mem               - asserted while a dirty line is flushed
//   proto_err                           - pulse with snoop_done for invalidate of an exclusive line
module snoop_bus_controller
  import snoop_pkg::*;
#(
  parameter int unsigned LINES     = 4,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned WB_CYCLES = 2,
  localparam int unsigned IDX_W = $clog2(LINES)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_op,
  input  logic [IDX_W-1:0]  snoop_index,
  input  logic [TAG_W-1:0]  snoop_tag,
  output logic              snoop_ready,
  input  logic              cpu_upd_valid,
  input  logic [IDX_W-1:0]  cpu_upd_index,
  input  logic [TAG_W-1:0]  cpu_upd_tag,
  input  logic [1:0]        cpu_upd_state,
  output logic              cpu_upd_stall,
  output logic              snoop_done,
  output logic              snoop_hit,
  output logic              write_back,
  output logic              abort_mem,
  output logic              proto_err
);

  localparam int unsigned CNT_W = (WB_CYCLES > 1) ? $clog2(WB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(WB_CYCLES - 1);

  fsm_state_e        r_state, w_state_next;
  bus_op_e           r_op;
  logic [IDX_W-1:0]  r_index;
  logic [TAG_W-1:0]  r_tag;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_hit, r_err;

  logic              w_accept;
  logic [TAG_W-1:0]  w_rd_tag;
  line_state_e       w_rd_state;
  logic              w_hit, w_snp_we, w_go_flush, w_err, w_cpu_we, w_idx_busy;
  line_state_e       w_snp_state;

  assign w_accept = snoop_valid && snoop_ready;
  assign w_cpu_we = cpu_upd_valid && !cpu_upd_stall;

  snoop_line_store #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_store (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_rd_index  (r_index),
    .o_rd_tag    (w_rd_tag),
    .o_rd_state  (w_rd_state),
    .i_snp_we    (w_snp_we),
    .i_snp_index (r_index),
    .i_snp_state (w_snp_state),
    .i_cpu_we    (w_cpu_we),
    .i_cpu_index (cpu_upd_index),
    .i_cpu_tag   (cpu_upd_tag),
    .i_cpu_state (to_line_state(cpu_upd_state))
  );

  // Lookup decode: the line-state change is committed on the edge leaving LOOKUP.
  always_comb begin
    w_hit       = (r_op != OpReserved) && (w_rd_state != LsInvalid) && (w_rd_tag == r_tag);
    w_snp_we    = 1'b0;
    w_snp_state = w_rd_state;
    w_go_flush  = 1'b0;
    w_err       = 1'b0;
    if ((r_state == StLookup) && w_hit) begin
      case (r_op)
        OpReadMiss: begin
          if (w_rd_state == LsExclusive) begin
            w_snp_we    = 1'b1;
            w_snp_state = LsShared;
            w_go_flush  = 1'b1;
          end
        end
        OpWriteMiss: begin
          w_snp_we    = 1'b1;
          w_snp_state = LsInvalid;
          w_go_flush  = (w_rd_state == LsExclusive);
        end
        OpInvalidate: begin
          // An exclusive owner should never see a bare invalidate.
          w_snp_we    = 1'b1;
          w_snp_state = LsInvalid;
          w_err       = (w_rd_state == LsExclusive);
        end
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // FSM next state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = StLookup;
      StLookup: w_state_next = w_go_flush ? StFlush : StDone;
      StFlush:  if (r_cnt == '0) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    snoop_ready   = (r_state == StIdle);
    snoop_done    = (r_state == StDone);
    snoop_hit     = (r_state == StDone) && r_hit;
    proto_err     = (r_state == StDone) && r_err;
    write_back    = (r_state == StFlush);
    abort_mem     = (r_state == StFlush);
    // Index held by an in-flight snoop, or by one being accepted right now.
    w_idx_busy    = ((r_state != StIdle) && (cpu_upd_index == r_index)) ||
                    (w_accept && (cpu_upd_index == snoop_index));
    cpu_upd_stall = reset_n && cpu_upd_valid && w_idx_busy;
  end

  // Request latch, lookup result and flush down-counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= OpReadMiss;
      r_index <= '0;
      r_tag   <= '0;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= bus_op_e'(snoop_op);
        r_index <= snoop_index;
        r_tag   <= snoop_tag;
      end
      if (r_state == StLookup) begin
        r_hit <= w_hit;
        r_err <= w_err;
        r_cnt <= w_go_flush ? CntLoad : '0;
      end else if ((r_state == StFlush) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule
